// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and types for the VRAM write controller.
// Region map, register indices and the controller FSM state enum.
package vram_pkg;

  localparam logic [12:0] TILE_BASE   = 13'h0000;
  localparam logic [12:0] ATTR_BASE   = 13'h0800;
  localparam logic [12:0] COLOR_BASE  = 13'h1800;
  localparam logic [12:0] COLOR_LIMIT = 13'h1810;

  localparam logic [3:0] REG_PTR_LO = 4'd0;
  localparam logic [3:0] REG_PTR_HI = 4'd1;
  localparam logic [3:0] REG_DATA   = 4'd2;
  localparam logic [3:0] REG_INCR   = 4'd3;
  localparam logic [3:0] REG_CNT_LO = 4'd4;
  localparam logic [3:0] REG_CNT_HI = 4'd5;
  localparam logic [3:0] REG_FILL   = 4'd6;
  localparam logic [3:0] REG_CTRL   = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    FILL_WAIT,
    FILL
  } state_t;

endpackage

// File: rtl/vram_write_controller_if.sv
// vram_write_controller_if: CPU register write bus (strobe, index, data).
// master drives reg_we/reg_addr/reg_wdata; slave (the controller) samples them.
interface vram_write_controller_if;
  logic       reg_we;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;

  modport master (
    output reg_we,
    output reg_addr,
    output reg_wdata
  );

  modport slave (
    input reg_we,
    input reg_addr,
    input reg_wdata
  );
endinterface

// File: rtl/vram_write_controller_write_fifo.sv
// write_fifo: synchronous posted-write FIFO with full/empty flags.
// Ports: clk, rst (sync active-low), push/wdata, pop/rdata (show-ahead), full, empty.
module write_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when it pops in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vram_write_controller.sv
// vram_write_controller: pointer/FIFO/fill sequencer for tile, attribute, colour RAM.
// Ports: CLK100MHz, rst (sync active-low), bus (register writes), three write ports, busy, err.
module vram_write_controller
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                     CLK100MHz,
  input  logic                     rst,
  vram_write_controller_if.slave   bus,
  output logic                     tile_memory_write_enable,
  output logic [10:0]              tile_memory_write_addr,
  output logic [7:0]               tile_memory_write_data,
  output logic                     attribute_memory_write_enable,
  output logic [11:0]              attribute_memory_write_addr,
  output logic [7:0]               attribute_memory_write_data,
  output logic                     color_memory_write_enable,
  output logic [3:0]               color_memory_write_addr,
  output logic [7:0]               color_memory_write_data,
  output logic                     busy,
  output logic                     err
);

  localparam int EW = ADDR_WIDTH + 8;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [7:0]            incr;
  logic [15:0]           cnt;
  logic [7:0]            fill_byte;

  logic                  we;
  logic [3:0]            idx;
  logic [7:0]            wd_in;
  logic                  in_idle;
  logic                  reg_hit;
  logic                  push;
  logic                  push_ok;
  logic                  pop;
  logic                  fill_go;
  logic                  full;
  logic                  empty;
  logic [EW-1:0]         head;
  logic                  wv;
  logic [ADDR_WIDTH-1:0] wa;
  logic [7:0]            wd;
  logic                  t_hit;
  logic                  a_hit;
  logic                  c_hit;
  logic                  bad;
  logic [11:0]           attr_off;
  logic                  err_set;

  assign we    = bus.reg_we;
  assign idx   = bus.reg_addr;
  assign wd_in = bus.reg_wdata;
  assign busy  = !empty || (state != IDLE);

  write_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (EW)
  ) u_fifo (
    .clk   (CLK100MHz),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .wdata ({ptr, wd_in}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nx = state;
    in_idle  = (state == IDLE);
    reg_hit  = we && (idx <= REG_FILL);
    pop      = !empty && (state != FILL);
    push     = we && (idx == REG_DATA) && in_idle;
    push_ok  = push && (!full || pop);
    fill_go  = we && (idx == REG_FILL) && in_idle && (cnt != '0);

    unique case (1'b1)
      (state == IDLE):      if (fill_go) state_nx = empty ? FILL : FILL_WAIT;
      (state == FILL_WAIT): if (empty) state_nx = FILL;
      (state == FILL):      if (cnt == 16'd1) state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase

    wv = 1'b0;
    wa = '0;
    wd = '0;
    if (state == FILL) begin
      wv = 1'b1;
      wa = ptr;
      wd = fill_byte;
    end else if (pop) begin
      wv = 1'b1;
      wa = head[EW-1:8];
      wd = head[7:0];
    end

    t_hit    = wv && (wa < ATTR_BASE);
    a_hit    = wv && (wa >= ATTR_BASE) && (wa < COLOR_BASE);
    c_hit    = wv && (wa >= COLOR_BASE) && (wa < COLOR_LIMIT);
    bad      = wv && (wa >= COLOR_LIMIT);
    attr_off = 12'(wa - ATTR_BASE);
    // Busy-time register writes and FIFO overflow drops also flag err.
    err_set  = bad || (reg_hit && !in_idle) || (push && !push_ok);
  end

  always_ff @(posedge CLK100MHz) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      incr      <= 8'd1;
      cnt       <= '0;
      fill_byte <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_idle && we) begin
        case (idx)
          REG_PTR_LO: ptr[7:0] <= wd_in;
          REG_PTR_HI: ptr[ADDR_WIDTH-1:8] <= wd_in[ADDR_WIDTH-9:0];
          REG_DATA:   if (push_ok) ptr <= ptr + ADDR_WIDTH'(incr);
          REG_INCR:   incr <= wd_in;
          REG_CNT_LO: cnt[7:0] <= wd_in;
          REG_CNT_HI: cnt[15:8] <= wd_in;
          REG_FILL:   if (fill_go) fill_byte <= wd_in;
          default:    ;
        endcase
      end
      if (state == FILL) begin
        ptr <= ptr + ADDR_WIDTH'(incr);
        cnt <= cnt - 16'd1;
      end
      if (err_set) err <= 1'b1;
      else if (we && (idx == REG_CTRL)) err <= 1'b0;
    end
  end

  always_ff @(posedge CLK100MHz) begin
    if (!rst) begin
      tile_memory_write_enable      <= 1'b0;
      tile_memory_write_addr        <= '0;
      tile_memory_write_data        <= '0;
      attribute_memory_write_enable <= 1'b0;
      attribute_memory_write_addr   <= '0;
      attribute_memory_write_data   <= '0;
      color_memory_write_enable     <= 1'b0;
      color_memory_write_addr       <= '0;
      color_memory_write_data       <= '0;
    end else begin
      tile_memory_write_enable      <= t_hit;
      attribute_memory_write_enable <= a_hit;
      color_memory_write_enable     <= c_hit;
      if (t_hit) begin
        tile_memory_write_addr <= wa[10:0];
        tile_memory_write_data <= wd;
      end
      if (a_hit) begin
        attribute_memory_write_addr <= attr_off;
        attribute_memory_write_data <= wd;
      end
      if (c_hit) begin
        color_memory_write_addr <= wa[3:0];
        color_memory_write_data <= wd;
      end
    end
  end

endmodule

// File: tb/tb_vram_write_controller.sv
// tb_vram_write_controller: randomized scoreboard bench for vram_write_controller.
// Expected writes come from an address-space model; a monitor pops and compares.
module tb_vram_write_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        te, ae, ce;
  logic [10:0] ta;
  logic [11:0] aa;
  logic [3:0]  ca;
  logic [7:0]  td, ad, cd;
  logic        busy, err;

  always #5 clk = ~clk;

  vram_write_controller_if bus ();

  vram_write_controller dut (
    .CLK100MHz                     (clk),
    .rst                           (rst),
    .bus                           (bus),
    .tile_memory_write_enable      (te),
    .tile_memory_write_addr        (ta),
    .tile_memory_write_data        (td),
    .attribute_memory_write_enable (ae),
    .attribute_memory_write_addr   (aa),
    .attribute_memory_write_data   (ad),
    .color_memory_write_enable     (ce),
    .color_memory_write_addr       (ca),
    .color_memory_write_data       (cd),
    .busy                          (busy),
    .err                           (err)
  );

  typedef struct {
    int port;
    int addr;
    int data;
  } exp_t;

  exp_t q[$];
  int compared   = 0;
  int mismatched = 0;
  int m_ptr, m_incr, m_cnt, m_err;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Unified address space: tile below 0x800, attribute below 0x1800,
  // 16 colour entries, everything above is discarded with an error.
  function automatic void emit(input int a, input int d);
    if (a < 'h800)       q.push_back('{0, a, d});
    else if (a < 'h1800) q.push_back('{1, a - 'h800, d});
    else if (a < 'h1810) q.push_back('{2, a - 'h1800, d});
    else                 m_err = 1;
  endfunction

  function automatic void m_reg(input int idx, input int d);
    case (idx)
      0: m_ptr = (m_ptr & 'h1F00) | d;
      1: m_ptr = (m_ptr & 'hFF) | ((d & 'h1F) << 8);
      2: begin
        emit(m_ptr, d);
        m_ptr = (m_ptr + m_incr) % 8192;
      end
      3: m_incr = d;
      4: m_cnt = (m_cnt & 'hFF00) | d;
      5: m_cnt = (m_cnt & 'hFF) | (d << 8);
      6: begin
        for (int i = 0; i < m_cnt; i++) begin
          emit(m_ptr, d);
          m_ptr = (m_ptr + m_incr) % 8192;
        end
        m_cnt = 0;
      end
      7: m_err = 0;
      default: ;
    endcase
  endfunction

  task automatic wr(input int idx, input int d);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = 4'(idx);
    bus.reg_wdata = 8'(d);
    @(posedge clk);
    #1;
    bus.reg_we = 1'b0;
  endtask

  task automatic mw(input int idx, input int d);
    wr(idx, d);
    m_reg(idx, d);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin : monitor
    int n, p, a, d;
    exp_t e;
    forever begin
      @(negedge clk);
      n = int'(te) + int'(ae) + int'(ce);
      if (n != 0) begin
        chk("one_hot_enable", n, 1);
        if (te) begin
          p = 0; a = int'(ta); d = int'(td);
        end else if (ae) begin
          p = 1; a = int'(aa); d = int'(ad);
        end else begin
          p = 2; a = int'(ca); d = int'(cd);
        end
        if (q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = q.pop_front();
          chk("write_port", p, e.port);
          chk("write_addr", a, e.addr);
          chk("write_data", d, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst           = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    m_ptr = 0; m_incr = 1; m_cnt = 0; m_err = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enables", int'({te, ae, ce}), 0);
    chk("reset_addrs", int'(ta) + int'(aa) + int'(ca), 0);
    chk("reset_data", int'(td) + int'(ad) + int'(cd), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Tile writes and DATA-to-enable latency.
    mw(0, 'h10);
    mw(1, 'h00);
    mw(2, 'hAA);
    chk("latency_n1", int'(te), 0);
    @(posedge clk);
    #1;
    chk("latency_n2", int'(te), 1);
    mw(2, 'hBB);
    wait_idle(n);

    // Attribute writes with incr 2; third write proves pointer 0x0804.
    mw(0, 'h00);
    mw(1, 'h08);
    mw(3, 2);
    mw(2, 'h11);
    mw(2, 'h22);
    wait_idle(n);
    mw(2, 'h33);
    wait_idle(n);

    // Fill crossing the end of colour memory.
    mw(0, 'h0E);
    mw(1, 'h18);
    mw(3, 1);
    mw(4, 3);
    mw(5, 0);
    mw(6, 'h5C);
    chk("fill_busy", int'(busy), 1);
    wait_idle(n);
    chk("fill_cycles", n, 3);
    chk("fill_err", int'(err), m_err);
    mw(7, 0);
    chk("ctrl_clear", int'(err), 0);

    // Back-to-back DATA writes, then pointer wrap past 0x1FFF.
    mw(0, 'h00);
    mw(1, 'h02);
    for (int i = 0; i < 5; i++) mw(2, int'($urandom_range(0, 255)));
    wait_idle(n);
    chk("burst_err", int'(err), 0);
    mw(0, 'hFF);
    mw(1, 'h1F);
    mw(2, 'h01);
    mw(2, 'h02);
    wait_idle(n);
    chk("wrap_err", int'(err), m_err);
    mw(7, 0);

    // Posted writes then fill; a DATA strobe while busy is ignored.
    mw(0, 'h00);
    mw(1, 'h03);
    mw(4, 4);
    mw(5, 0);
    mw(2, 'h31);
    mw(2, 'h32);
    mw(2, 'h33);
    mw(6, 'hE7);
    wr(2, 'h99);
    m_err = 1;
    chk("wait_busy", int'(busy), 1);
    wait_idle(n);
    chk("busy_write_err", int'(err), m_err);
    mw(7, 0);

    // Randomized register traffic.
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 9))
        0: mw(0, int'($urandom_range(0, 255)));
        1: mw(1, int'($urandom_range(0, 31)));
        2, 3, 4, 5: mw(2, int'($urandom_range(0, 255)));
        6: mw(3, int'($urandom_range(0, 255)));
        7: begin
          mw(4, int'($urandom_range(0, 5)));
          mw(5, 0);
        end
        8: begin
          mw(6, int'($urandom_range(0, 255)));
          wait_idle(n);
          chk("rand_fill_err", int'(err), m_err);
        end
        default: begin
          wait_idle(n);
          chk("rand_err", int'(err), m_err);
          mw(7, 0);
          chk("rand_ctrl_clear", int'(err), 0);
        end
      endcase
    end
    wait_idle(n);
    mw(7, 0);

    // Reset in the 2nd cycle of a 100-byte fill.
    mw(0, 'h00);
    mw(1, 'h01);
    mw(3, 1);
    mw(4, 100);
    mw(5, 0);
    wr(6, 'hC3);
    q.push_back('{0, 'h100, 'hC3});
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_enables", int'({te, ae, ce}), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(err), 0);
    m_ptr = 0; m_incr = 1; m_cnt = 0; m_err = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    mw(6, 'h44);
    chk("zero_count_fill", int'(busy), 0);
    mw(2, 'h5A);
    wait_idle(n);
    mw(1, 'h1F);
    mw(0, 'hFF);
    mw(2, 'h01);
    wait_idle(n);
    chk("post_reset_err", int'(err), m_err);
    mw(7, 0);
    chk("post_reset_clear", int'(err), 0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
